alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  In-order instruction issue controller in front of the ALU/register-file datapath (top).
//  Buffers incoming 32-bit instructions in a small queue with a valid/ready handshake.
//  Tracks in-flight register writes with a per-register scoreboard and stalls on RAW hazards.
//  Drives the datapath instruction port, inserting NOPs (32'h0) on every cycle it does not issue.
// PARAMETERS
//  DEPTH   4   queue entries; must be a power of 2, >= 2
//  WB_LAT  3   cycles from issue to register write-back; >= 1
//  NREG    32  architectural registers, addressed by 5-bit fields
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   asynchronous, active-high reset
//  in_instr     in   32  instruction to enqueue
//  in_valid     in   1   in_instr is valid
//  in_ready     out  1   queue can accept; = !full (combinational)
//  flush        in   1   synchronous queue flush
//  issue_instr  out  32  registered instruction to datapath; 32'h0 when not issuing
//  issue_valid  out  1   registered; 1 when issue_instr holds an issued instruction
//  busy         out  1   queue non-empty OR any scoreboard counter non-zero
//  state        out  2   FSM state: 0 IDLE, 1 ISSUE, 2 STALL
// BEHAVIOUR
//  Decode: op=[31:26], rd=[25:21], rs=[20:16], rt=[15:11]. op==0 is a NOP.
//    NOPs are queued and issued but never read or write the scoreboard.
//  Enqueue: on an edge with in_valid&&in_ready; no push when full, even if a pop occurs that cycle.
//  Scoreboard: one counter per register, width clog2(WB_LAT+1).
//    R0 is tracked like every other register.
//  Issue rule (evaluated in the cycle): queue non-empty && !flush && sb[rs]==0 && sb[rt]==0.
//    If true: pop the head; issue_instr<=head; issue_valid<=1; sb[rd]<=WB_LAT (op!=0).
//    If false: issue_instr<=0; issue_valid<=0.
//  Counters: each non-zero counter decrements by 1 every edge.
//    A set and a decrement on the same register in the same edge: the set wins.
//  Latency: an instruction pushed at edge N into an empty, hazard-free controller drives
//    issue_instr after edge N+1. No bypass from in_instr.
//  RAW: a producer issued at edge E releases its dependent consumer at edge E+WB_LAT+1.
//    This leaves exactly WB_LAT NOP cycles between them.
//  Independent instructions issue back-to-back at one per cycle.
//  FSM (registered):
//    IDLE: queue empty -> stays; non-empty -> ISSUE.
//    ISSUE: head issuable -> ISSUE; hazard -> STALL; queue empty after pop -> IDLE.
//    STALL: hazard clears -> ISSUE; flush -> IDLE.
//  Flush: empties the queue at the edge, and no issue occurs that cycle.
//    A push in the same cycle as flush is dropped.
//    Scoreboard keeps counting down, so busy stays 1 until all counters reach 0.
//  Pointers: wrap modulo DEPTH; occupancy count is 0..DEPTH.
//  Reset (async, any time, including mid-stall):
//    queue empty; all counters 0; issue_instr=0; issue_valid=0; state=IDLE.
//    Outputs: in_ready=1, busy=0.
// CONFIGURATION
//  ISSUE_STATS_EN defined:
//    Adds output stall_cnt[15:0]: cycles spent in STALL.
//    Adds output issue_cnt[15:0]: issued non-NOP instructions.
//    Both counters saturate at 16'hFFFF and clear on rst only.
//  ISSUE_STATS_EN undefined: both ports and their counters are absent; all other behaviour is identical.
// TESTING
//  Reset: rst=1 for 20ns, no clock edges:
//    issue_instr=0, issue_valid=0, in_ready=1, busy=0, state=0.
//  Independent: push 32'h7421000A then 32'h6C420002 on consecutive cycles:
//    issued on consecutive cycles, no NOP between.
//  RAW (WB_LAT=3): push 32'h7421000A, then 32'h54611000 (reads R1):
//    3 NOP cycles, state=2 for 3 cycles, then second issued.
//  Full (DEPTH=4): hold the head stalled and offer 5 instructions:
//    in_ready=0 after the 4th push; the 5th is accepted after the first pop.
//  Flush in STALL: queue emptied, in_ready=1, state=IDLE next cycle.
//    busy=1 until the scoreboard drains, then busy=0.
//  Async reset mid-RAW-stall: assert rst between edges:
//    all outputs return to reset values immediately; the queued consumer is never issued.
//  ISSUE_STATS_EN: after the RAW scenario, stall_cnt=3 and issue_cnt=2.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-side handshake and datapath issue bus of alu_issue_ctrl.
interface alu_issue_ctrl_if;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] issue_instr;
  logic        issue_valid;

  modport master (
    output in_instr, in_valid, flush,
    input  in_ready, issue_instr, issue_valid
  );

  modport slave (
    input  in_instr, in_valid, flush,
    output in_ready, issue_instr, issue_valid
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// In-order issue controller: instruction queue, per-register write-back scoreboard, RAW stall.
// Optional ISSUE_STATS_EN adds saturating stall_cnt / issue_cnt outputs.
module alu_issue_ctrl #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WB_LAT = 3,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_ctrl_if.slave   bus,
  output logic              busy,
  output logic [1:0]        state
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       issue_cnt
`endif
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam int unsigned CW   = $clog2(WB_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } state_t;

  logic [31:0]     mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CNTW-1:0] count;
  logic [CW-1:0]   sb [NREG];
  state_t          state_q;
  state_t          state_d;
  logic [31:0]     issue_instr_q;
  logic            issue_valid_q;

  logic [31:0] head;
  logic [5:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        full;
  logic        empty;
  logic        push;
  logic        head_ok;
  logic        can_issue;
  logic        hazard;
  logic        sb_any;

  // Head decode and issue decision
  always_comb begin
    head      = mem[rd_ptr];
    op        = head[31:26];
    rd        = head[25:21];
    rs        = head[20:16];
    rt        = head[15:11];
    full      = (count == CNTW'(DEPTH));
    empty     = (count == '0);
    push      = bus.in_valid && !full && !bus.flush;
    head_ok   = (op == 6'd0) || ((sb[rs] == '0) && (sb[rt] == '0));
    can_issue = !empty && !bus.flush && head_ok;
    hazard    = !empty && !head_ok;
  end

  assign bus.in_ready    = !full;
  assign bus.issue_instr = issue_instr_q;
  assign bus.issue_valid = issue_valid_q;
  assign state           = state_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_instr;
  end

  // Queue pointers and occupancy; flush discards everything including a same-cycle push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)      wr_ptr <= wr_ptr + PW'(1);
      if (can_issue) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CNTW'(push) - CNTW'(can_issue);
    end
  end

  // Scoreboard: a new write-back reservation overrides the countdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) sb[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (can_issue && (op != 6'd0) && (rd == 5'(i))) sb[i] <= CW'(WB_LAT);
        else if (sb[i] != '0)                           sb[i] <= sb[i] - CW'(1);
      end
    end
  end

  always_comb begin
    sb_any = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (sb[i] != '0) sb_any = 1'b1;
    end
    busy = !empty || sb_any;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_instr_q <= '0;
      issue_valid_q <= 1'b0;
    end else if (can_issue) begin
      issue_instr_q <= head;
      issue_valid_q <= 1'b1;
    end else begin
      issue_instr_q <= '0;
      issue_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!empty && !bus.flush) state_d = ISSUE;
      ISSUE: begin
        if (bus.flush || empty)                state_d = IDLE;
        else if (hazard)                       state_d = STALL;
        else if ((count == CNTW'(1)) && !push) state_d = IDLE;
      end
      STALL: begin
        if (bus.flush)   state_d = IDLE;
        else if (!hazard) state_d = ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ISSUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if ((state_q == STALL) && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (can_issue && (op != 6'd0) && (issue_cnt != 16'hFFFF)) issue_cnt <= issue_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: table of instruction pairs plus full/flush/reset sequences.
module tb_alu_issue_ctrl;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [1:0] state;
`ifdef ISSUE_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] issue_cnt;
`endif

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .state (state)
`ifdef ISSUE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .issue_cnt (issue_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stall_seen   = 0;
  int issued_total = 0;
  logic [31:0] exp_q[$];
  int          iss_cyc[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          gap;
  } vec_t;

  vec_t vt[7];

  initial begin
    clk = 1'b0;
    #25;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int rt);
    return {6'(op), 5'(rd), 5'(rs), 5'(rt), 11'h0};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Scoreboard monitor: every issued instruction must match the next accepted one in order
  always @(negedge clk) begin
    if (!rst) begin
      if (state == 2'd2) stall_seen++;
      if (bus.issue_valid) begin
        issued_total++;
        iss_cyc.push_back(cyc);
        if (exp_q.size() == 0) fail_now($sformatf("unexpected_issue %h", bus.issue_instr));
        else check("issue_instr", bus.issue_instr, exp_q.pop_front());
      end else begin
        check("nop_instr", bus.issue_instr, 32'h0);
      end
    end
  end

  // Offer one instruction from the next falling edge until accepted; acc = accepting edge number
  task automatic drive(input logic [31:0] v, output int acc, output logic rdy0);
    @(negedge clk);
    bus.in_instr = v;
    bus.in_valid = 1'b1;
    rdy0 = bus.in_ready;
    acc  = -1;
    for (int t = 0; t < 20; t++) begin
      if (bus.in_ready) begin
        acc = cyc + 1;
        @(posedge clk);
        exp_q.push_back(v);
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (acc < 0) fail_now($sformatf("push_timeout %h", v));
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_instr = 32'h0;
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 60; t++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    if (t == 60) fail_now("drain_timeout");
  endtask

  task automatic wait_stall();
    int t;
    for (t = 0; t < 20; t++) begin
      if (state == 2'd2) break;
      @(negedge clk);
    end
    if (t == 20) fail_now("stall_timeout");
  endtask

  int   ea, eb, ed;
  logic r0;
  int   base;

  initial begin
    vt[0] = '{32'h7421000A, 32'h6C420002, 0};  // independent
    vt[1] = '{32'h7421000A, 32'h54611000, 3};  // RAW on rs=R1
    vt[2] = '{32'h6C420002, 32'h54611000, 3};  // RAW on rt=R2
    vt[3] = '{32'h00000021, 32'h54611000, 0};  // NOP producer writes nothing
    vt[4] = '{32'h7421000A, 32'h00210000, 0};  // NOP consumer reads nothing
    vt[5] = '{32'h0C000000, 32'h6C420002, 3};  // R0 is tracked
    vt[6] = '{32'h7421000A, 32'h74200000, 0};  // WAW only, no stall

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = 32'h0;
    bus.flush    = 1'b0;
    #15;
    check("rst_issue_instr", bus.issue_instr, 32'h0);
    check("rst_issue_valid", 32'(bus.issue_valid), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_state", 32'(state), 32'h0);
    #5 rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      wait_idle();
      iss_cyc.delete();
      stall_seen = 0;
      drive(vt[i].a, ea, r0);
      drive(vt[i].b, eb, r0);
      idle();
      wait_idle();
      if (iss_cyc.size() != 2) fail_now($sformatf("vec%0d_issue_count %0d", i, iss_cyc.size()));
      else begin
        check($sformatf("vec%0d_latency", i), 32'(iss_cyc[0] - ea), 32'd1);
        check($sformatf("vec%0d_gap", i), 32'(iss_cyc[1] - iss_cyc[0] - 1), 32'(vt[i].gap));
        check($sformatf("vec%0d_stall_cycles", i), 32'(stall_seen), 32'(vt[i].gap));
      end
    end

    // Full queue behind a stalled head; fifth offer accepted the edge after the head pops
    wait_idle();
    iss_cyc.delete();
    drive(32'h7421000A, ea, r0);
    drive(32'h54611000, ea, r0);
    drive(enc(5, 4, 0, 0), ea, r0);
    drive(enc(5, 5, 0, 0), ea, r0);
    drive(enc(5, 6, 0, 0), ea, r0);
    drive(enc(5, 7, 0, 0), ed, r0);
    check("full_in_ready", 32'(r0), 32'h0);
    idle();
    wait_idle();
    if (iss_cyc.size() != 6) fail_now($sformatf("full_issue_count %0d", iss_cyc.size()));
    else begin
      check("full_accept_edge", 32'(ed - iss_cyc[1]), 32'd1);
      check("full_c_release", 32'(iss_cyc[1] - iss_cyc[0]), 32'd4);
      check("full_back_to_back", 32'(iss_cyc[5] - iss_cyc[1]), 32'd4);
    end

    // Flush while stalled; a same-cycle push is dropped and the scoreboard keeps draining
    wait_idle();
    drive(32'h7421000A, ea, r0);
    drive(32'h54611000, ea, r0);
    idle();
    wait_stall();
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00000077;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = 32'h0;
    check("flush_in_ready", 32'(bus.in_ready), 32'h1);
    check("flush_state", 32'(state), 32'h0);
    check("flush_busy_hold", 32'(busy), 32'h1);
    @(negedge clk);
    check("flush_busy_drain", 32'(busy), 32'h0);
    check("flush_state_idle", 32'(state), 32'h0);

    // Asynchronous reset between edges in the middle of a RAW stall
    wait_idle();
    drive(32'h7421000A, ea, r0);
    drive(32'h54611000, ea, r0);
    idle();
    wait_stall();
    check("pre_rst_busy", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_issue_instr", bus.issue_instr, 32'h0);
    check("arst_issue_valid", 32'(bus.issue_valid), 32'h0);
    check("arst_in_ready", 32'(bus.in_ready), 32'h1);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_state", 32'(state), 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst  = 1'b0;
    base = issued_total;
    repeat (8) @(negedge clk);
    check("arst_consumer_dropped", 32'(issued_total - base), 32'd0);

`ifdef ISSUE_STATS_EN
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    drive(32'h7421000A, ea, r0);
    drive(32'h54611000, ea, r0);
    idle();
    wait_idle();
    check("stats_stall_cnt", 32'(stall_cnt), 32'd3);
    check("stats_issue_cnt", 32'(issue_cnt), 32'd2);
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
